// File: rtl/x_stream_source_pkg.sv
// Shared types and default sizes for the x-stream source and the engine top.
package x_stream_source_pkg;

  localparam int XSRC_WIDTH = 16;
  localparam int XSRC_LENX  = 8;

  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    STREAM,
    DRAIN
  } xsrc_state_t;

endpackage

// File: rtl/memory.sv
// Simple dual-port buffer: synchronous read with one cycle of latency, read-before-write.
module memory #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8,
  parameter int ADDRW = 3
) (
  input  logic                    clk,
  input  logic                    we,
  input  logic [ADDRW-1:0]        waddr,
  input  logic signed [WIDTH-1:0] wdata,
  input  logic                    re,
  input  logic [ADDRW-1:0]        raddr,
  output logic signed [WIDTH-1:0] rdata
);

  logic signed [WIDTH-1:0] ram [DEPTH];

  always_ff @(posedge clk) begin
    if (we) ram[waddr] <= wdata;
    if (re) rdata <= ram[raddr];
  end

endmodule

// File: rtl/xsrc_skid_fifo.sv
// Two-entry registered FIFO that absorbs reads in flight while the consumer stalls.
module xsrc_skid_fifo #(
  parameter int WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    push,
  input  logic                    pop,
  input  logic signed [WIDTH-1:0] din,
  output logic [1:0]              count,
  output logic signed [WIDTH-1:0] head
);

  logic signed [WIDTH-1:0] slot [2];
  logic                    wr_ptr;
  logic                    rd_ptr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count  <= 2'd0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      unique case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; the count alone says which slots hold data.
  always_ff @(posedge clk) begin
    if (push) slot[wr_ptr] <= din;
  end

  assign head = slot[rd_ptr];

endmodule

// File: rtl/x_stream_source.sv
// Replays a preloaded LENX-word vector as a valid/ready stream, one or more frames per start.
module x_stream_source
  import x_stream_source_pkg::*;
#(
  parameter int WIDTH  = XSRC_WIDTH,
  parameter int LENX   = XSRC_LENX,
  parameter int ADDRX  = 3,
  parameter int FRAMEW = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    wr_en,
  input  logic [ADDRX-1:0]        wr_addr,
  input  logic signed [WIDTH-1:0] wr_data,
  input  logic                    start,
  input  logic [FRAMEW-1:0]       frames,
  output logic signed [WIDTH-1:0] m_data_out_x,
  output logic                    m_valid_x,
  input  logic                    m_ready_x,
  output logic                    busy,
  output logic                    done
);

  localparam int BW = ADDRX + FRAMEW;

  xsrc_state_t             state, state_nxt;
  logic [ADDRX-1:0]        rd_addr;
  logic [FRAMEW-1:0]       frame_cnt;
  logic [FRAMEW-1:0]       frames_q;
  logic [BW-1:0]           beat_cnt;
  logic [BW-1:0]           last_beat;
  logic                    vld_p1;
  logic signed [WIDTH-1:0] rdata_p1;
  logic signed [WIDTH-1:0] head;
  logic [1:0]              count;
  logic                    mem_we, ren, room, last_rd, hs, last_hs, push, pop;

  assign busy      = (state != IDLE);
  assign mem_we    = wr_en && !busy && (32'(wr_addr) < LENX);
  assign room      = (count == 2'd0) || ((count == 2'd1) && !vld_p1);
  assign ren       = (state == PRIME) || ((state == STREAM) && room);
  assign last_rd   = (rd_addr == ADDRX'(LENX - 1)) && (frame_cnt == frames_q - FRAMEW'(1));
  assign last_beat = BW'(BW'(LENX) * BW'(frames_q) - BW'(1));
  assign hs        = m_valid_x && m_ready_x;
  assign last_hs   = hs && (beat_cnt == last_beat);

  // A word arriving from the buffer bypasses the FIFO when it is empty and the consumer takes it.
  assign pop  = (count != 2'd0) && m_ready_x;
  assign push = vld_p1 && !((count == 2'd0) && m_ready_x);

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:   if (start) state_nxt = PRIME;
      PRIME:  state_nxt = last_rd ? DRAIN : STREAM;
      STREAM: if (ren && last_rd) state_nxt = DRAIN;
      DRAIN:  if (last_hs) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      rd_addr   <= '0;
      frame_cnt <= '0;
      frames_q  <= FRAMEW'(1);
      beat_cnt  <= '0;
      vld_p1    <= 1'b0;
      done      <= 1'b0;
    end else begin
      state  <= state_nxt;
      vld_p1 <= ren;
      done   <= (state == DRAIN) && last_hs;
      if ((state == IDLE) && start) begin
        frames_q  <= (frames == '0) ? FRAMEW'(1) : frames;
        rd_addr   <= '0;
        frame_cnt <= '0;
        beat_cnt  <= '0;
      end else begin
        if (ren) begin
          if (rd_addr == ADDRX'(LENX - 1)) begin
            rd_addr   <= '0;
            frame_cnt <= frame_cnt + FRAMEW'(1);
          end else begin
            rd_addr <= rd_addr + ADDRX'(1);
          end
        end
        if (hs) beat_cnt <= beat_cnt + BW'(1);
      end
    end
  end

  // ---- stage p1: buffer read data, one cycle after the read is issued ----
  memory #(.WIDTH(WIDTH), .DEPTH(LENX), .ADDRW(ADDRX)) u_buf (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wr_addr),
    .wdata (wr_data),
    .re    (ren),
    .raddr (rd_addr),
    .rdata (rdata_p1)
  );

  xsrc_skid_fifo #(.WIDTH(WIDTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (rdata_p1),
    .count (count),
    .head  (head)
  );

  assign m_valid_x = (count != 2'd0) || vld_p1;

  always_comb begin
    m_data_out_x = '0;
    if (count != 2'd0)  m_data_out_x = head;
    else if (vld_p1)    m_data_out_x = rdata_p1;
  end

endmodule

// File: tb/tb_x_stream_source.sv
// Scoreboard bench for x_stream_source: expected words queued at start, checked on each handshake.
module tb_x_stream_source;

  localparam int WIDTH  = 16;
  localparam int LENX   = 8;
  localparam int ADDRX  = 3;
  localparam int FRAMEW = 4;

  logic                    clk = 1'b0;
  logic                    reset = 1'b0;
  logic                    wr_en = 1'b0;
  logic [ADDRX-1:0]        wr_addr = '0;
  logic signed [WIDTH-1:0] wr_data = '0;
  logic                    start = 1'b0;
  logic [FRAMEW-1:0]       frames = '0;
  logic signed [WIDTH-1:0] m_data_out_x;
  logic                    m_valid_x;
  logic                    m_ready_x = 1'b0;
  logic                    busy;
  logic                    done;

  int errors = 0;
  int checks = 0;
  int beats  = 0;
  bit mon_en = 1'b0;
  logic signed [WIDTH-1:0] exp_q [$];
  logic signed [WIDTH-1:0] vec [LENX];

  x_stream_source #(.WIDTH(WIDTH), .LENX(LENX), .ADDRX(ADDRX), .FRAMEW(FRAMEW)) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .start        (start),
    .frames       (frames),
    .m_data_out_x (m_data_out_x),
    .m_valid_x    (m_valid_x),
    .m_ready_x    (m_ready_x),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  // Scoreboard and stall-stability monitor, sampled mid-cycle.
  initial begin
    bit prev_stall;
    logic signed [WIDTH-1:0] prev_data;
    logic signed [WIDTH-1:0] exp;
    prev_stall = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (prev_stall) begin
          checks++;
          if (!m_valid_x || m_data_out_x !== prev_data) begin
            errors++;
            $display("FAIL stall_hold valid=%0b data=%0d required valid=1 data=%0d",
                     m_valid_x, m_data_out_x, prev_data);
          end
        end
        if (m_valid_x && m_ready_x) begin
          checks++;
          beats++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL extra_beat data=%0d required no beat", m_data_out_x);
          end else begin
            exp = exp_q.pop_front();
            if (m_data_out_x !== exp) begin
              errors++;
              $display("FAIL beat_data data=%0d required %0d", m_data_out_x, exp);
            end
          end
        end
        prev_stall = m_valid_x && !m_ready_x;
        prev_data  = m_data_out_x;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_vec();
    for (int i = 0; i < LENX; i++) begin
      wr_en   = 1'b1;
      wr_addr = ADDRX'(i);
      wr_data = vec[i];
      tick();
    end
    wr_en = 1'b0;
  endtask

  // Queues the expected words, pulses start for one cycle; returns at cycle 1 (PRIME).
  task automatic start_run(input logic [FRAMEW-1:0] f, input int nf);
    for (int k = 0; k < nf; k++)
      for (int i = 0; i < LENX; i++) exp_q.push_back(vec[i]);
    beats  = 0;
    frames = f;
    start  = 1'b1;
    tick();
    start  = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) tick();
    checks++;
    if (m_valid_x !== 1'b0 || m_data_out_x !== '0) begin
      errors++;
      $display("FAIL reset_out valid=%0b data=%0d required 0 0", m_valid_x, m_data_out_x);
    end
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctl busy=%0b done=%0b required 0 0", busy, done);
    end
    @(negedge clk);
    reset = 1'b1;
    tick();
  endtask

  task automatic test_single_frame();
    bit ok;
    for (int i = 0; i < LENX; i++) vec[i] = WIDTH'(i + 1);
    load_vec();
    m_ready_x = 1'b1;
    mon_en    = 1'b1;
    start_run(FRAMEW'(1), 1);
    checks++;
    if (m_valid_x !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL prime_cycle valid=%0b busy=%0b required 0 1", m_valid_x, busy);
    end
    tick();
    checks++;
    if (m_valid_x !== 1'b1 || m_data_out_x !== 16'sd1) begin
      errors++;
      $display("FAIL first_beat_latency valid=%0b data=%0d required 1 1", m_valid_x, m_data_out_x);
    end
    repeat (7) tick();
    checks++;
    if (busy !== 1'b1 || m_data_out_x !== 16'sd8 || done !== 1'b0) begin
      errors++;
      $display("FAIL last_beat_cycle busy=%0b data=%0d done=%0b required 1 8 0", busy, m_data_out_x, done);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || done !== 1'b1 || m_valid_x !== 1'b0) begin
      errors++;
      $display("FAIL done_cycle busy=%0b done=%0b valid=%0b required 0 1 0", busy, done, m_valid_x);
    end
    tick();
    checks++;
    if (done !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse_width done=%0b required 0", done);
    end
    checks++;
    if (beats != 8 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL single_count beats=%0d left=%0d required 8 0", beats, exp_q.size());
    end
    wait_done(0, ok);
  endtask

  task automatic test_multi_frame();
    bit ok;
    int gaps;
    gaps = 0;
    start_run(FRAMEW'(3), 3);
    for (int c = 2; c <= 25; c++) begin
      tick();
      if (!m_valid_x) gaps++;
    end
    checks++;
    if (gaps != 0) begin
      errors++;
      $display("FAIL frame_gaps bubbles=%0d required 0", gaps);
    end
    wait_done(10, ok);
    checks++;
    if (!ok || beats != 24 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL multi_count done=%0b beats=%0d left=%0d required 1 24 0", ok, beats, exp_q.size());
    end
    tick();
    start_run(FRAMEW'(0), 1);
    wait_done(40, ok);
    checks++;
    if (!ok || beats != 8 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL frames_zero done=%0b beats=%0d left=%0d required 1 8 0", ok, beats, exp_q.size());
    end
    tick();
  endtask

  task automatic test_random_ready();
    bit ok;
    vec[0] = -16'sd3;  vec[1] = 16'sd127; vec[2] = -16'sd128; vec[3] = 16'sd0;
    vec[4] = 16'sd5;   vec[5] = 16'sd6;   vec[6] = 16'sd7;    vec[7] = 16'sd8;
    load_vec();
    for (int run = 1; run <= 2; run++) begin
      start_run(FRAMEW'(run), run);
      ok = 1'b0;
      for (int i = 0; i < 300; i++) begin
        m_ready_x = 1'($urandom_range(0, 1));
        tick();
        if (done) begin
          ok = 1'b1;
          break;
        end
      end
      checks++;
      if (!ok || beats != 8 * run || exp_q.size() != 0) begin
        errors++;
        $display("FAIL random_ready run=%0d done=%0b beats=%0d left=%0d required 1 %0d 0",
                 run, ok, beats, exp_q.size(), 8 * run);
      end
      m_ready_x = 1'b1;
      tick();
    end
  endtask

  task automatic test_start_write_busy();
    bit ok;
    for (int i = 0; i < LENX; i++) vec[i] = WIDTH'(i + 1);
    load_vec();
    start_run(FRAMEW'(1), 1);
    repeat (3) tick();
    start   = 1'b1;
    wr_en   = 1'b1;
    wr_addr = '0;
    wr_data = 16'sh0055;
    tick();
    start   = 1'b0;
    wr_en   = 1'b0;
    wait_done(20, ok);
    checks++;
    if (!ok || beats != 8 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL busy_ignore done=%0b beats=%0d left=%0d required 1 8 0", ok, beats, exp_q.size());
    end
    tick();
    start_run(FRAMEW'(1), 1);
    wait_done(20, ok);
    checks++;
    if (!ok || beats != 8 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL write_dropped done=%0b beats=%0d left=%0d required 1 8 0", ok, beats, exp_q.size());
    end
    tick();
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit saw_done;
    start_run(FRAMEW'(1), 1);
    repeat (4) tick();
    mon_en = 1'b0;
    reset  = 1'b0;
    #1;
    checks++;
    if (m_valid_x !== 1'b0 || busy !== 1'b0 || m_data_out_x !== '0) begin
      errors++;
      $display("FAIL async_abort valid=%0b busy=%0b data=%0d required 0 0 0", m_valid_x, busy, m_data_out_x);
    end
    exp_q.delete();
    tick();
    @(negedge clk);
    reset = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (done) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      errors++;
      $display("FAIL abort_done done=1 required 0");
    end
    for (int i = 0; i < LENX; i++) vec[i] = WIDTH'(11 + i);
    load_vec();
    mon_en = 1'b1;
    start_run(FRAMEW'(1), 1);
    wait_done(20, ok);
    checks++;
    if (!ok || beats != 8 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL restart done=%0b beats=%0d left=%0d required 1 8 0", ok, beats, exp_q.size());
    end
    tick();
  endtask

  task automatic test_ready_low();
    bit ok;
    int bad;
    int gaps;
    bad  = 0;
    gaps = 0;
    m_ready_x = 1'b0;
    start_run(FRAMEW'(1), 1);
    for (int c = 2; c <= 11; c++) begin
      tick();
      if (!m_valid_x || m_data_out_x !== vec[0]) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL hold_word0 bad_cycles=%0d required 0", bad);
    end
    m_ready_x = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (!m_valid_x) gaps++;
      tick();
    end
    checks++;
    if (gaps != 0) begin
      errors++;
      $display("FAIL resume_gaps bubbles=%0d required 0", gaps);
    end
    wait_done(10, ok);
    checks++;
    if (!ok || beats != 8 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL ready_low_count done=%0b beats=%0d left=%0d required 1 8 0", ok, beats, exp_q.size());
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_multi_frame();
    test_random_ready();
    test_start_write_busy();
    test_reset_mid();
    test_ready_low();
    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
